// File: rtl/alu_io_bridge.sv
// ---------------------------------------------------------------------------
// alu_io_bridge
//
// Purpose:
//   Bridges the CPU IO register file to the shared ALU. A rising edge on
//   the STA bit of the CPU control word starts one transaction. The bridge
//   latches the operands and the operation, holds the ALU start level, and
//   waits for completion with a timeout. It then captures the results and
//   reports sticky completion/error flags that firmware polls.
//
// Ports:
//   CLK, RST_N         clock (rising edge), asynchronous active-low reset
//   io_control         CPU control word: [1:0] mode, [4:2] alu_type, [5] STA
//   io_dataoutA/B      CPU operands; only the low MAX_SQRT_WIDTH bits are used
//   io_status          {0.., timeout, type_err, busy, done}
//   io_datainA/B       zero-extended captured FOUT / POUT
//   X_IN, Y_IN         latched operands to the ALU
//   alu_type           latched one-hot operation (100 mul, 010 div, 001 sqrt/pow)
//   mode_type          latched mode
//   alu_start          ALU start level, high in LAUNCH and WAIT
//   FOUT, POUT         ALU results
//   alu_is_done        ALU completion
// ---------------------------------------------------------------------------
module alu_io_bridge #(
    parameter int GENERAL_REG_WIDTH = 16,
    parameter int MAX_SQRT_WIDTH    = 13,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [GENERAL_REG_WIDTH-1:0] io_control,
    input  logic [GENERAL_REG_WIDTH-1:0] io_dataoutA,
    input  logic [GENERAL_REG_WIDTH-1:0] io_dataoutB,
    output logic [GENERAL_REG_WIDTH-1:0] io_status,
    output logic [GENERAL_REG_WIDTH-1:0] io_datainA,
    output logic [GENERAL_REG_WIDTH-1:0] io_datainB,
    output logic [MAX_SQRT_WIDTH-1:0]    X_IN,
    output logic [MAX_SQRT_WIDTH-1:0]    Y_IN,
    output logic [2:0]                   alu_type,
    output logic [1:0]                   mode_type,
    output logic                         alu_start,
    input  logic [MAX_SQRT_WIDTH-1:0]    FOUT,
    input  logic [MAX_SQRT_WIDTH-1:0]    POUT,
    input  logic                         alu_is_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic                      sta_q, sta_d;
    logic [15:0]               cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic                      type_err_q, type_err_d;
    logic                      timeout_q, timeout_d;
    logic [MAX_SQRT_WIDTH-1:0] x_in_q, x_in_d;
    logic [MAX_SQRT_WIDTH-1:0] y_in_q, y_in_d;
    logic [MAX_SQRT_WIDTH-1:0] fout_q, fout_d;
    logic [MAX_SQRT_WIDTH-1:0] pout_q, pout_d;
    logic [2:0]                alu_type_q, alu_type_d;
    logic [1:0]                mode_q, mode_d;

    logic sta;
    logic sta_rise;
    logic busy;

    // Upper control/operand bits carry nothing for this block.
    logic unused_bits;
    assign unused_bits = ^{io_control[GENERAL_REG_WIDTH-1:6],
                           io_dataoutA[GENERAL_REG_WIDTH-1:MAX_SQRT_WIDTH],
                           io_dataoutB[GENERAL_REG_WIDTH-1:MAX_SQRT_WIDTH]};

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    assign sta      = io_control[5];
    assign sta_rise = sta & ~sta_q;

    always_comb begin
        state_d    = state_q;
        sta_d      = sta;
        cnt_d      = cnt_q;
        done_d     = done_q;
        type_err_d = type_err_q;
        timeout_d  = timeout_q;
        x_in_d     = x_in_q;
        y_in_d     = y_in_q;
        fout_d     = fout_q;
        pout_d     = pout_q;
        alu_type_d = alu_type_q;
        mode_d     = mode_q;

        case (state_q)
            IDLE: begin
                if (sta_rise) begin
                    x_in_d     = io_dataoutA[MAX_SQRT_WIDTH-1:0];
                    y_in_d     = io_dataoutB[MAX_SQRT_WIDTH-1:0];
                    alu_type_d = io_control[4:2];
                    mode_d     = io_control[1:0];
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    if (is_onehot3(io_control[4:2])) begin
                        type_err_d = 1'b0;
                        state_d    = LAUNCH;
                    end else begin
                        type_err_d = 1'b1;
                        state_d    = ERR;
                    end
                end
            end
            LAUNCH: begin
                cnt_d   = 16'(TIMEOUT_CYCLES);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end
                // Completion beats both abort and timeout expiry in the same cycle.
                if (alu_is_done) begin
                    fout_d  = FOUT;
                    pout_d  = POUT;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (!sta) begin
                    state_d = IDLE;
                end else if (cnt_q <= 16'd1) begin
                    timeout_d = 1'b1;
                    state_d   = ERR;
                end
            end
            DONE, ERR: begin
                if (!sta) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            sta_q      <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            type_err_q <= 1'b0;
            timeout_q  <= 1'b0;
            x_in_q     <= '0;
            y_in_q     <= '0;
            fout_q     <= '0;
            pout_q     <= '0;
            alu_type_q <= '0;
            mode_q     <= '0;
        end else begin
            state_q    <= state_d;
            sta_q      <= sta_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            type_err_q <= type_err_d;
            timeout_q  <= timeout_d;
            x_in_q     <= x_in_d;
            y_in_q     <= y_in_d;
            fout_q     <= fout_d;
            pout_q     <= pout_d;
            alu_type_q <= alu_type_d;
            mode_q     <= mode_d;
        end
    end

    assign busy       = (state_q == LAUNCH) || (state_q == WAIT);
    assign alu_start  = busy;
    assign io_status  = {{(GENERAL_REG_WIDTH-4){1'b0}}, timeout_q, type_err_q, busy, done_q};
    assign io_datainA = {{(GENERAL_REG_WIDTH-MAX_SQRT_WIDTH){1'b0}}, fout_q};
    assign io_datainB = {{(GENERAL_REG_WIDTH-MAX_SQRT_WIDTH){1'b0}}, pout_q};
    assign X_IN       = x_in_q;
    assign Y_IN       = y_in_q;
    assign alu_type   = alu_type_q;
    assign mode_type  = mode_q;

endmodule
